bg_fg_classifier: RTL and testbench



---
 rtl/bg_model_pkg.sv | 33 +++
 rtl/bg_var_compare.sv | 42 ++++
 rtl/bg_fg_classifier.sv | 143 ++++++++++++++
 tb/tb_bg_fg_classifier.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_model_pkg.sv
// Shared definitions for the per-pixel background model in SRAM.
// Used by both the background-update writer and the classifier reader.
package bg_model_pkg;

   localparam int H_MAX      = 640;
   localparam int V_MAX      = 480;
   localparam int LOG2N      = 4;
   localparam int SUM_W      = 12;
   localparam int SUMSQ_W    = 20;
   localparam int SUMSQ_LO_W = 4;
   localparam int H_W        = 10;
   localparam int V_W        = 9;
   localparam int ADDR_W     = 20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_CALC,
      S_OUT
   } state_t;

   // Each pixel owns two consecutive words: low word at 2n, high word at 2n+1.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [H_W-1:0] h,
                                                   input logic [V_W-1:0] v,
                                                   input logic           hi,
                                                   input int unsigned    h_max = H_MAX);
      int unsigned n;
      n = 32'(v) * h_max + 32'(h);
      return {n[ADDR_W-2:0], hi};
   endfunction

endpackage

// File: rtl/bg_var_compare.sv
// Combinational mean/variance test of one pixel against its N-frame model.
// All arithmetic is scaled by N so it stays exact in integers.
module bg_var_compare
   import bg_model_pkg::*;
#(
   parameter int K2        = 9,
   parameter int VAR_FLOOR = 16
) (
   input  logic [7:0]         gray,
   input  logic [SUM_W-1:0]   sum,
   input  logic [SUMSQ_W-1:0] sumsq,
   output logic               fg,
   output logic [7:0]         mean
);

   localparam logic [23:0] FLOOR_SCALED = 24'(VAR_FLOOR << (2 * LOG2N));
   localparam logic [3:0]  K2_U         = 4'(K2);

   logic signed [12:0] diff;
   logic [11:0]        diff_mag;
   logic [23:0]        d2;
   logic [23:0]        sum_sq;
   logic signed [24:0] var_raw;
   logic [23:0]        var_clamped;
   logic [23:0]        var_eff;
   logic [27:0]        thresh;

   // A corrupt model can make N*sumsq - sum^2 negative; treat that as zero variance.
   always_comb begin
      diff        = $signed({1'b0, gray, {LOG2N{1'b0}}}) - $signed({1'b0, sum});
      diff_mag    = diff[12] ? 12'(-diff) : 12'(diff);
      d2          = 24'(diff_mag) * 24'(diff_mag);
      sum_sq      = 24'(sum) * 24'(sum);
      var_raw     = $signed({1'b0, sumsq, {LOG2N{1'b0}}}) - $signed({1'b0, sum_sq});
      var_clamped = var_raw[24] ? '0 : var_raw[23:0];
      var_eff     = (var_clamped > FLOOR_SCALED) ? var_clamped : FLOOR_SCALED;
      thresh      = 28'(K2_U) * 28'(var_eff);
      fg          = 28'(d2) > thresh;
      mean        = sum[SUM_W-1:LOG2N];
   end

endmodule

// File: rtl/bg_fg_classifier.sv
// Foreground classifier: fetches each pixel's background model from shared SRAM
// and flags pixels that deviate from the mean by more than sqrt(K2) sigma.
module bg_fg_classifier #(
   parameter int H_MAX     = 640,
   parameter int V_MAX     = 480,
   parameter int K2        = 9,
   parameter int VAR_FLOOR = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [7:0]  i_gray,
   input  logic        i_sof,
   input  logic        i_model_valid,
   output logic        o_sram_rd,
   output logic [19:0] o_sram_addr,
   input  logic        i_sram_gnt,
   input  logic [15:0] i_sram_dq,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_fg,
   output logic [7:0]  o_gray,
   output logic [7:0]  o_mean
);

   import bg_model_pkg::*;

   localparam logic [H_W-1:0] H_LAST = H_W'(H_MAX - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_MAX - 1);

   state_t         state;
   state_t         next_state;
   logic [H_W-1:0] h;
   logic [V_W-1:0] v;
   logic [7:0]     gray_q;
   logic [7:0]     mean_q;
   logic [7:0]     calc_mean;
   logic           fg_q;
   logic           calc_fg;
   logic [15:0]    word_lo;
   logic [15:0]    word_hi;
   logic           accept;
   logic           handshake;

   assign accept    = (state == S_IDLE) && i_valid;
   assign handshake = (state == S_OUT) && i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (i_valid) next_state = i_model_valid ? S_RD_LO : S_OUT;
         S_RD_LO: if (i_sram_gnt) next_state = S_RD_HI;
         S_RD_HI: if (i_sram_gnt) next_state = S_CALC;
         S_CALC:  next_state = S_OUT;
         S_OUT:   if (i_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      o_sram_rd   = 1'b0;
      o_sram_addr = '0;
      case (state)
         S_IDLE:  o_ready = 1'b1;
         S_RD_LO: begin
            o_sram_rd   = 1'b1;
            o_sram_addr = pixel_addr(h, v, 1'b0, H_MAX);
         end
         S_RD_HI: begin
            o_sram_rd   = 1'b1;
            o_sram_addr = pixel_addr(h, v, 1'b1, H_MAX);
         end
         S_OUT:   o_valid = 1'b1;
         default: ;
      endcase
   end

   // The counters name the pixel in flight; they advance only once it is delivered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h <= '0;
         v <= '0;
      end else if (accept && i_sof) begin
         h <= '0;
         v <= '0;
      end else if (handshake) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         gray_q  <= '0;
         fg_q    <= 1'b0;
         mean_q  <= '0;
         word_lo <= '0;
         word_hi <= '0;
      end else begin
         if (accept) begin
            gray_q <= i_gray;
            if (!i_model_valid) begin
               fg_q   <= 1'b0;
               mean_q <= '0;
            end
         end
         if (state == S_RD_LO && i_sram_gnt) word_lo <= i_sram_dq;
         if (state == S_RD_HI && i_sram_gnt) word_hi <= i_sram_dq;
         if (state == S_CALC) begin
            fg_q   <= calc_fg;
            mean_q <= calc_mean;
         end
      end
   end

   bg_var_compare #(
      .K2        (K2),
      .VAR_FLOOR (VAR_FLOOR)
   ) u_var_compare (
      .gray  (gray_q),
      .sum   (word_lo[SUM_W-1:0]),
      .sumsq ({word_hi, word_lo[15:SUM_W]}),
      .fg    (calc_fg),
      .mean  (calc_mean)
   );

   assign o_fg   = fg_q;
   assign o_gray = gray_q;
   assign o_mean = mean_q;

endmodule

// File: tb/tb_bg_fg_classifier.sv
// Self-checking bench for bg_fg_classifier: table vectors, corner sequences and
// randomized pixels against an arithmetic reference model, on a reduced raster.
module tb_bg_fg_classifier;

   import bg_model_pkg::*;

   localparam int TB_H      = 16;
   localparam int TB_V      = 4;
   localparam int MEM_WORDS = 2 * TB_H * TB_V;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_gray;
   logic        i_sof;
   logic        i_model_valid;
   logic        o_sram_rd;
   logic [19:0] o_sram_addr;
   logic        i_sram_gnt;
   logic [15:0] i_sram_dq;
   logic        o_valid;
   logic        i_ready;
   logic        o_fg;
   logic [7:0]  o_gray;
   logic [7:0]  o_mean;

   logic [15:0] sram [0:MEM_WORDS-1];

   int   vectors     = 0;
   int   miscompares = 0;
   int   bh          = 0;
   int   bv          = 0;
   logic rand_gnt    = 1'b0;

   typedef struct {
      logic [7:0] gray;
      logic       sof;
      logic       mv;
      int         sum;
      int         sumsq;
      logic       fg;
      logic [7:0] mean;
   } vec_t;

   vec_t tbl [12];

   int   c, s, x, g_r, sum_r, sumsq_r;
   logic sof_r, mv_r;

   bg_fg_classifier #(
      .H_MAX (TB_H),
      .V_MAX (TB_V)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_gray        (i_gray),
      .i_sof         (i_sof),
      .i_model_valid (i_model_valid),
      .o_sram_rd     (o_sram_rd),
      .o_sram_addr   (o_sram_addr),
      .i_sram_gnt    (i_sram_gnt),
      .i_sram_dq     (i_sram_dq),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_fg          (o_fg),
      .o_gray        (o_gray),
      .o_mean        (o_mean)
   );

   always #5 i_clk = ~i_clk;

   assign i_sram_dq = sram[o_sram_addr[6:0]];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: foreground iff (N*g - sum)^2 > K2 * max(N*sumsq - sum^2, VAR_FLOOR*N^2).
   function automatic logic ref_fg(input int g, input int sum, input int sumsq, input logic mv);
      longint diff, var_est;
      diff    = 16 * longint'(g) - longint'(sum);
      var_est = 16 * longint'(sumsq) - longint'(sum) * longint'(sum);
      if (var_est < 4096) var_est = 4096;
      return mv && (diff * diff > 9 * var_est);
   endfunction

   function automatic logic [7:0] ref_mean(input int sum, input logic mv);
      return mv ? 8'(sum / 16) : 8'd0;
   endfunction

   function automatic int next_n(input logic sof);
      return sof ? 0 : bv * TB_H + bh;
   endfunction

   task automatic load_model(input int n, input int sum, input int sumsq);
      logic [19:0] sq;
      logic [11:0] sm;
      sq = 20'(sumsq);
      sm = 12'(sum);
      sram[2*n]   = {sq[3:0], sm};
      sram[2*n+1] = sq[19:4];
   endtask

   task automatic advance_raster();
      if (bh == TB_H - 1) begin
         bh = 0;
         bv = (bv == TB_V - 1) ? 0 : bv + 1;
      end else begin
         bh++;
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] g, input logic sof, input logic mv,
                                 input int stall_lo, input int stall_hi, input int bp,
                                 input logic exp_fg, input logic [7:0] exp_mean);
      int         n, cycles, phase, nogrant, rd_cycles, lo_left, hi_left;
      logic       fg_seen;
      logic [7:0] gray_seen, mean_seen;
      cycles = 0;
      while (o_ready !== 1'b1 && cycles < 10) begin
         @(negedge i_clk);
         cycles++;
      end
      check_output("ready", o_ready, 1);
      if (sof) begin
         bh = 0;
         bv = 0;
      end
      n             = bv * TB_H + bh;
      i_valid       = 1'b1;
      i_gray        = g;
      i_sof         = sof;
      i_model_valid = mv;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid       = 1'b0;
      i_sof         = 1'b0;
      i_gray        = 8'($urandom);
      i_model_valid = 1'($urandom);
      cycles = 1; phase = 0; nogrant = 0; rd_cycles = 0;
      lo_left = stall_lo; hi_left = stall_hi;
      while (o_valid !== 1'b1 && cycles < 40) begin
         if (o_sram_rd === 1'b1) begin
            rd_cycles++;
            check_output("sram_addr", o_sram_addr, 2 * n + phase);
            if (phase == 0 && lo_left > 0) begin
               i_sram_gnt = 1'b0;
               lo_left--;
            end else if (phase == 1 && hi_left > 0) begin
               i_sram_gnt = 1'b0;
               hi_left--;
            end else if (rand_gnt) begin
               i_sram_gnt = ($urandom_range(0, 3) != 0);
            end else begin
               i_sram_gnt = 1'b1;
            end
            if (i_sram_gnt) phase++;
            else            nogrant++;
         end else begin
            i_sram_gnt = 1'($urandom);
         end
         @(negedge i_clk);
         cycles++;
      end
      check_output("valid_timeout", o_valid, 1);
      check_output("latency", cycles, (mv ? 4 : 1) + nogrant);
      check_output("read_cycles", rd_cycles, mv ? 2 + nogrant : 0);
      check_output("fg", o_fg, exp_fg);
      check_output("mean", o_mean, exp_mean);
      check_output("gray", o_gray, g);
      fg_seen   = o_fg;
      gray_seen = o_gray;
      mean_seen = o_mean;
      for (int i = 0; i < bp; i++) begin
         i_ready = 1'b0;
         @(negedge i_clk);
         check_output("hold", {o_valid, o_ready, o_fg, o_gray, o_mean},
                      {1'b1, 1'b0, fg_seen, gray_seen, mean_seen});
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      advance_raster();
      check_output("release", {o_valid, o_ready}, 2'b01);
   endtask

   task automatic reset_mid_read();
      load_model(0, 1600, 160000);
      i_valid       = 1'b1;
      i_model_valid = 1'b1;
      i_sof         = 1'b0;
      i_gray        = 8'd55;
      i_sram_gnt    = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      check_output("rd_before_reset", o_sram_rd, 1);
      #2 i_rst_n = 1'b0;
      #1;
      check_output("rd_async_drop", o_sram_rd, 0);
      check_output("reset_ready", o_ready, 1);
      check_output("reset_addr", o_sram_addr, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      bh = 0;
      bv = 0;
      @(negedge i_clk);
      check_output("post_reset_idle", {o_valid, o_ready, o_fg, o_mean, o_gray},
                   {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
   endtask

   initial begin
      tbl[0]  = '{8'd100, 1'b1, 1'b1, 1600, 160000, 1'b0, 8'd100};
      tbl[1]  = '{8'd110, 1'b0, 1'b1, 1600, 160000, 1'b0, 8'd100};
      tbl[2]  = '{8'd120, 1'b0, 1'b1, 1600, 160000, 1'b1, 8'd100};
      tbl[3]  = '{8'd0,   1'b0, 1'b1, 1600, 160000, 1'b1, 8'd100};
      tbl[4]  = '{8'd112, 1'b0, 1'b1, 1600, 160000, 1'b0, 8'd100};
      tbl[5]  = '{8'd113, 1'b0, 1'b1, 1600, 160000, 1'b1, 8'd100};
      tbl[6]  = '{8'd77,  1'b0, 1'b0, 1600, 160000, 1'b0, 8'd0};
      tbl[7]  = '{8'd6,   1'b0, 1'b1, 100,  0,      1'b0, 8'd6};
      tbl[8]  = '{8'd200, 1'b0, 1'b1, 100,  0,      1'b1, 8'd6};
      tbl[9]  = '{8'd250, 1'b0, 1'b1, 1600, 200000, 1'b0, 8'd100};
      tbl[10] = '{8'd251, 1'b0, 1'b1, 1600, 200000, 1'b1, 8'd100};
      tbl[11] = '{8'd255, 1'b0, 1'b0, 1600, 200000, 1'b0, 8'd0};

      for (int i = 0; i < MEM_WORDS; i++) sram[i] = '0;
      i_rst_n = 1'b1; i_valid = 1'b0; i_gray = '0; i_sof = 1'b0;
      i_model_valid = 1'b0; i_sram_gnt = 1'b1; i_ready = 1'b1;
      #1 i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      check_output("rst_valid", o_valid, 0);
      check_output("rst_ready", o_ready, 1);
      check_output("rst_fg", o_fg, 0);
      check_output("rst_sram_rd", o_sram_rd, 0);
      check_output("rst_addr", o_sram_addr, 0);
      check_output("rst_gray", o_gray, 0);
      check_output("rst_mean", o_mean, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      check_output("pkg_addr_last_lo", pixel_addr(10'd639, 9'd479, 1'b0), 614398);
      check_output("pkg_addr_last_hi", pixel_addr(10'd639, 9'd479, 1'b1), 614399);
      check_output("pkg_addr_line_end", pixel_addr(10'd639, 9'd0, 1'b1), 1279);

      for (int i = 0; i < 12; i++) begin
         load_model(next_n(tbl[i].sof), tbl[i].sum, tbl[i].sumsq);
         apply_stimulus(tbl[i].gray, tbl[i].sof, tbl[i].mv, 0, 0, 0, tbl[i].fg, tbl[i].mean);
      end

      load_model(next_n(1'b0), 1600, 160000);
      apply_stimulus(8'd120, 1'b0, 1'b1, 0, 3, 0, 1'b1, 8'd100);
      load_model(next_n(1'b0), 1600, 160000);
      apply_stimulus(8'd110, 1'b0, 1'b1, 2, 0, 0, 1'b0, 8'd100);
      load_model(next_n(1'b0), 1600, 160000);
      apply_stimulus(8'd120, 1'b0, 1'b1, 0, 0, 5, 1'b1, 8'd100);

      reset_mid_read();
      load_model(0, 1600, 160000);
      apply_stimulus(8'd100, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8'd100);

      // Walk a full reduced frame to exercise both counter wraps.
      apply_stimulus(8'd10, 1'b1, 1'b0, 0, 0, 0, 1'b0, 8'd0);
      while (!(bh == TB_H - 1 && bv == TB_V - 1))
         apply_stimulus(8'd10, 1'b0, 1'b0, 0, 0, 0, 1'b0, 8'd0);
      load_model(TB_H * TB_V - 1, 1600, 160000);
      apply_stimulus(8'd100, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8'd100);
      load_model(0, 1600, 160000);
      apply_stimulus(8'd120, 1'b0, 1'b1, 0, 0, 0, 1'b1, 8'd100);

      rand_gnt = 1'b1;
      for (int k = 0; k < 120; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            sum_r   = int'($urandom_range(0, 4095));
            sumsq_r = int'($urandom_range(0, 1048575));
            c       = sum_r / 16;
         end else begin
            c = int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 40));
            sum_r = 0;
            sumsq_r = 0;
            for (int j = 0; j < 16; j++) begin
               x = c + int'($urandom_range(0, 2 * s)) - s;
               if (x < 0)   x = 0;
               if (x > 255) x = 255;
               sum_r   += x;
               sumsq_r += x * x;
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            g_r = c + int'($urandom_range(0, 120)) - 60;
            if (g_r < 0)   g_r = 0;
            if (g_r > 255) g_r = 255;
         end else begin
            g_r = int'($urandom_range(0, 255));
         end
         sof_r = ($urandom_range(0, 19) == 0);
         mv_r  = ($urandom_range(0, 7) != 0);
         load_model(next_n(sof_r), sum_r, sumsq_r);
         apply_stimulus(8'(g_r), sof_r, mv_r, 0, 0, int'($urandom_range(0, 2)),
                        ref_fg(g_r, sum_r, sumsq_r, mv_r), ref_mean(sum_r, mv_r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
